// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_driver
// Description : Multiplexed seven-segment display driver. Lights one digit
//               per rising edge of the 5 kHz scan clock. The scan clock is
//               synchronised into the clk100MHz domain and edge-detected.
//               It is never used as a clock. Each frame shows a snapshot of
//               the value taken when the scan wraps to digit 0.
// Ports       : clk100MHz_i  system clock (100 MHz)
//               rst_i        asynchronous active-high reset
//               scan_clk_i   scan square wave, treated as data
//               enable_i     1 = scanning, 0 = display dark
//               value_i      hex nibbles, digit 0 in bits [3:0] (rightmost)
//               dp_in_i      decimal point request per digit
//               blank_lz_i   1 = blank leading zeros
//               an_o         anode enables, one active bit when lit
//               seg_o        segments, seg_o[0]=a .. seg_o[6]=g
//               dp_o         decimal point segment
//               digit_idx_o  index of the digit currently driven
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_driver #(
  parameter int DIGITS     = 8,   // number of digits / anodes (2..8)
  parameter int ACTIVE_LOW = 1    // 1: an/seg/dp active-low, 0: active-high
) (
  input  logic                       clk100MHz_i,
  input  logic                       rst_i,
  input  logic                       scan_clk_i,
  input  logic                       enable_i,
  input  logic [4*DIGITS-1:0]        value_i,
  input  logic [DIGITS-1:0]          dp_in_i,
  input  logic                       blank_lz_i,
  output logic [DIGITS-1:0]          an_o,
  output logic [6:0]                 seg_o,
  output logic                       dp_o,
  output logic [$clog2(DIGITS)-1:0]  digit_idx_o
);

  localparam int              IDX_W    = $clog2(DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
  // Level that turns an anode/segment/dp off.
  localparam logic            INACT    = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  // Active-high gfedcba pattern for one hex nibble.
  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0: pat = 7'h3F;
      4'h1: pat = 7'h06;
      4'h2: pat = 7'h5B;
      4'h3: pat = 7'h4F;
      4'h4: pat = 7'h66;
      4'h5: pat = 7'h6D;
      4'h6: pat = 7'h7D;
      4'h7: pat = 7'h07;
      4'h8: pat = 7'h7F;
      4'h9: pat = 7'h6F;
      4'hA: pat = 7'h77;
      4'hB: pat = 7'h7C;
      4'hC: pat = 7'h39;
      4'hD: pat = 7'h5E;
      4'hE: pat = 7'h79;
      default: pat = 7'h71;
    endcase
    return pat;
  endfunction

  // --------------------------------------------------------------------------
  // Scan clock synchroniser and rising-edge detect
  // --------------------------------------------------------------------------
  logic s1_q, s2_q, s3_q;
  logic tick;

  always_ff @(posedge clk100MHz_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= scan_clk_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign tick = s2_q & ~s3_q;

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] shadow_val_q, shadow_val_d;
  logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;

  always_ff @(posedge clk100MHz_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q        <= LAST_IDX;
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      an_q         <= {DIGITS{INACT}};
      seg_q        <= {7{INACT}};
      dp_q         <= INACT;
    end else begin
      idx_q        <= idx_d;
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next index and frame snapshot. Disable dominates a coincident tick so the
  // scan always restarts cleanly at digit 0 after re-enable.
  // --------------------------------------------------------------------------
  always_comb begin
    idx_d        = idx_q;
    shadow_val_d = shadow_val_q;
    shadow_dp_d  = shadow_dp_q;
    if (!enable_i) begin
      idx_d = LAST_IDX;
    end else if (tick) begin
      if (idx_q == LAST_IDX) begin
        idx_d        = '0;
        shadow_val_d = value_i;
        shadow_dp_d  = dp_in_i;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Digit selection and leading-zero detection, evaluated on the next-state
  // index and shadow so the registered outputs line up with digit_idx_o.
  // --------------------------------------------------------------------------
  logic [DIGITS-1:0] upper_zero;   // nibbles i..DIGITS-1 are all zero
  logic [3:0]        sel_nib;
  logic              sel_dp;
  logic              sel_blank;
  logic              zero_run;

  always_comb begin
    zero_run   = 1'b1;
    upper_zero = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run      = zero_run & (shadow_val_d[4*i +: 4] == 4'h0);
      upper_zero[i] = zero_run;
    end
  end

  always_comb begin
    sel_nib   = 4'h0;
    sel_dp    = 1'b0;
    sel_blank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (IDX_W'(i) == idx_d) begin
        sel_nib   = shadow_val_d[4*i +: 4];
        sel_dp    = shadow_dp_d[i];
        // Digit 0 always shows, so a zero value still reads "0".
        sel_blank = blank_lz_i && (i != 0) && upper_zero[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output next-state. Outputs only move on a tick (or go dark on disable),
  // so a stalled scan clock freezes the display.
  // --------------------------------------------------------------------------
  always_comb begin
    an_d  = an_q;
    seg_d = seg_q;
    dp_d  = dp_q;
    if (!enable_i || (tick && sel_blank)) begin
      an_d  = {DIGITS{INACT}};
      seg_d = {7{INACT}};
      dp_d  = INACT;
    end else if (tick) begin
      for (int i = 0; i < DIGITS; i++) begin
        an_d[i] = (IDX_W'(i) == idx_d) ? ~INACT : INACT;
      end
      seg_d = decode(sel_nib) ^ {7{INACT}};
      dp_d  = sel_dp ^ INACT;
    end
  end

  assign an_o        = an_q;
  assign seg_o       = seg_q;
  assign dp_o        = dp_q;
  assign digit_idx_o = idx_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_driver
// Description : Directed self-checking bench for seg7_scan_driver with
//               DIGITS=8, ACTIVE_LOW=1. Expected values are hand-derived from
//               the segment table (inverted for active-low drive).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

  logic        clk;
  logic        clk_run;
  logic        rst;
  logic        scan_clk;
  logic        enable;
  logic [31:0] value;
  logic [7:0]  dp_in;
  logic        blank_lz;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [2:0]  didx;

  int checks = 0;
  int errors = 0;

  seg7_scan_driver #(.DIGITS(8), .ACTIVE_LOW(1)) dut (
    .clk100MHz_i (clk),
    .rst_i       (rst),
    .scan_clk_i  (scan_clk),
    .enable_i    (enable),
    .value_i     (value),
    .dp_in_i     (dp_in),
    .blank_lz_i  (blank_lz),
    .an_o        (an),
    .seg_o       (seg),
    .dp_o        (dp),
    .digit_idx_o (didx)
  );

  // Clock held still until the reset-state checks are done.
  initial begin
    clk = 1'b0;
    wait (clk_run);
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full scan period of 40 clocks; outputs settled on return.
  task automatic do_tick();
    @(negedge clk);
    scan_clk = 1'b1;
    repeat (20) @(negedge clk);
    scan_clk = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  initial begin
    clk_run  = 1'b0;
    rst      = 1'b1;
    scan_clk = 1'b0;
    enable   = 1'b0;
    value    = 32'h0;
    dp_in    = 8'h0;
    blank_lz = 1'b0;

    // Reset with no clock edges at all.
    #3;
    chk("rst_an",   32'(an),   32'hFF);
    chk("rst_seg",  32'(seg),  32'h7F);
    chk("rst_dp",   32'(dp),   32'h1);
    chk("rst_idx",  32'(didx), 32'h7);

    clk_run = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    enable = 1'b1;
    value  = 32'h1234ABCD;
    repeat (4) @(negedge clk);
    chk("en_no_tick_an", 32'(an), 32'hFF);

    // First tick, with exact latency: unchanged after 2 edges, lit after 3.
    @(negedge clk);
    scan_clk = 1'b1;
    repeat (2) @(negedge clk);
    chk("lat_hold_an", 32'(an), 32'hFF);
    @(negedge clk);
    chk("t1_an",  32'(an),   32'hFE);
    chk("t1_seg", 32'(seg),  32'h21);   // d
    chk("t1_idx", 32'(didx), 32'h0);
    chk("t1_dp",  32'(dp),   32'h1);
    repeat (17) @(negedge clk);
    scan_clk = 1'b0;
    repeat (20) @(negedge clk);

    do_tick();
    chk("t2_an",  32'(an),  32'hFD);
    chk("t2_seg", 32'(seg), 32'h46);    // C
    do_tick();
    chk("t3_an",  32'(an),  32'hFB);
    chk("t3_seg", 32'(seg), 32'h03);    // b
    do_tick();
    chk("t4_an",  32'(an),   32'hF7);
    chk("t4_seg", 32'(seg),  32'h08);   // A
    chk("t4_idx", 32'(didx), 32'h3);

    // Mid-frame value change must not reach digits 4..7 of this frame.
    value = 32'hFFFFFFFF;
    do_tick();
    chk("t5_seg", 32'(seg), 32'h19);    // 4
    do_tick();
    chk("t6_seg", 32'(seg), 32'h30);    // 3
    do_tick();
    chk("t7_seg", 32'(seg), 32'h24);    // 2
    do_tick();
    chk("t8_an",  32'(an),  32'h7F);
    chk("t8_seg", 32'(seg), 32'h79);    // 1
    do_tick();
    chk("t9_an",  32'(an),   32'hFE);
    chk("t9_seg", 32'(seg),  32'h0E);   // F from new snapshot
    chk("t9_idx", 32'(didx), 32'h0);

    // Stalled scan clock: everything holds.
    repeat (100) @(negedge clk);
    chk("stall_an",  32'(an),   32'hFE);
    chk("stall_idx", 32'(didx), 32'h0);

    // Leading-zero blanking, picked up at the next frame.
    blank_lz = 1'b1;
    value    = 32'h000000A0;
    dp_in    = 8'h02;
    for (int k = 1; k <= 8; k++) do_tick();
    chk("bl0_an",  32'(an),  32'hFE);
    chk("bl0_seg", 32'(seg), 32'h40);
    chk("bl0_dp",  32'(dp),  32'h1);
    do_tick();
    chk("bl1_an",  32'(an),  32'hFD);
    chk("bl1_seg", 32'(seg), 32'h08);
    chk("bl1_dp",  32'(dp),  32'h0);
    for (int k = 2; k <= 7; k++) begin
      do_tick();
      chk("blk_an", 32'(an), 32'hFF);
    end
    chk("bl7_seg", 32'(seg),  32'h7F);
    chk("bl7_dp",  32'(dp),   32'h1);
    chk("bl7_idx", 32'(didx), 32'h7);

    // Disable while digit 4 is showing.
    for (int k = 0; k <= 4; k++) do_tick();
    chk("pre_dis_idx", 32'(didx), 32'h4);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("dis_an",  32'(an),   32'hFF);
    chk("dis_idx", 32'(didx), 32'h7);
    value = 32'h00000005;
    dp_in = 8'h00;
    do_tick();
    chk("dis_tick_an",  32'(an),   32'hFF);
    chk("dis_tick_idx", 32'(didx), 32'h7);
    enable = 1'b1;
    do_tick();
    chk("reen_idx", 32'(didx), 32'h0);
    chk("reen_an",  32'(an),   32'hFE);
    chk("reen_seg", 32'(seg),  32'h12);  // 5, fresh snapshot
    chk("reen_dp",  32'(dp),   32'h1);

    // Asynchronous reset pulse between clock edges at digit 5.
    for (int k = 1; k <= 5; k++) do_tick();
    chk("pre_rst_idx", 32'(didx), 32'h5);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_an",  32'(an),   32'hFF);
    chk("arst_seg", 32'(seg),  32'h7F);
    chk("arst_dp",  32'(dp),   32'h1);
    chk("arst_idx", 32'(didx), 32'h7);
    @(negedge clk);
    rst   = 1'b0;
    value = 32'h0;
    do_tick();
    chk("prst_idx", 32'(didx), 32'h0);
    chk("prst_an",  32'(an),   32'hFE);
    chk("prst_seg", 32'(seg),  32'h40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
